// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: drives the 2x4 anode decoder and the
// segment encoder's digit value, with per-frame snapshot, blank guard and zero blanking.
module display_scan_ctrl #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       En,
  input  logic       Lz_en,
  input  logic [3:0] Dig3,
  input  logic [3:0] Dig2,
  input  logic [3:0] Dig1,
  input  logic [3:0] Dig0,
  output logic       Sel1,
  output logic       Sel2,
  output logic       H,
  output logic [3:0] Digit,
  output logic       Frame_tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(PRESCALE - BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    GUARD = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    slot;
  logic [3:0]    s3, s2, s1, s0;
  logic          lz;

  logic          slot_end;
  logic          frame_start;
  logic [1:0]    next_slot;
  logic [3:0]    next_digit;
  logic          next_h;

  // Shadow digit for slot k: k=0 is the leftmost (most significant) digit.
  function automatic logic [3:0] pick(input logic [1:0] k, input logic [3:0] a3,
                                      input logic [3:0] a2, input logic [3:0] a1,
                                      input logic [3:0] a0);
    case (k)
      2'd0:    return a3;
      2'd1:    return a2;
      2'd2:    return a1;
      default: return a0;
    endcase
  endfunction

  // A slot is blanked when it and all more-significant digits are zero;
  // the rightmost slot always lights so a value of 0 still shows "0".
  function automatic logic zero_blank(input logic [1:0] k, input logic lz_on,
                                      input logic [3:0] a3, input logic [3:0] a2,
                                      input logic [3:0] a1);
    case (k)
      2'd0:    return lz_on && (a3 == 4'd0);
      2'd1:    return lz_on && (a3 == 4'd0) && (a2 == 4'd0);
      2'd2:    return lz_on && (a3 == 4'd0) && (a2 == 4'd0) && (a1 == 4'd0);
      default: return 1'b0;
    endcase
  endfunction

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    slot_end    = 1'b0;
    frame_start = 1'b0;
    next_slot   = 2'd0;
    next_digit  = 4'd0;
    next_h      = 1'b0;
    slot_end    = (state == GUARD) && (cnt == SLOT_LAST);
    frame_start = En && ((state == IDLE) || (slot_end && (slot == 2'd3)));
    next_slot   = slot + 2'd1;
    if (frame_start) begin
      // A new frame shows the live inputs, which are captured on this same edge.
      next_slot  = 2'd0;
      next_digit = Dig3;
      next_h     = !zero_blank(2'd0, Lz_en, Dig3, Dig2, Dig1);
    end else begin
      next_digit = pick(next_slot, s3, s2, s1, s0);
      next_h     = !zero_blank(next_slot, lz, s3, s2, s1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      slot       <= 2'd0;
      s3         <= 4'd0;
      s2         <= 4'd0;
      s1         <= 4'd0;
      s0         <= 4'd0;
      lz         <= 1'b0;
      H          <= 1'b0;
      Digit      <= 4'd0;
      Frame_tick <= 1'b0;
    end else begin
      Frame_tick <= 1'b0;
      if (!En) begin
        state <= IDLE;
        cnt   <= '0;
        slot  <= 2'd0;
        H     <= 1'b0;
        Digit <= s3;
      end else begin
        if (frame_start) begin
          s3         <= Dig3;
          s2         <= Dig2;
          s1         <= Dig1;
          s0         <= Dig0;
          lz         <= Lz_en;
          Frame_tick <= 1'b1;
        end
        case (state)
          IDLE: begin
            state <= SHOW;
            cnt   <= '0;
            slot  <= next_slot;
            H     <= next_h;
            Digit <= next_digit;
          end
          SHOW: begin
            if (cnt == SHOW_LAST) begin
              state <= GUARD;
              H     <= 1'b0;
            end
            cnt <= cnt + CW'(1);
          end
          GUARD: begin
            if (slot_end) begin
              state <= SHOW;
              cnt   <= '0;
              slot  <= next_slot;
              H     <= next_h;
              Digit <= next_digit;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            slot  <= 2'd0;
            H     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Sel1 = slot[1];
  assign Sel2 = slot[0];

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: directed scenarios plus random digit,
// enable and suppression traffic compared against a frame-position reference model.
module tb_display_scan_ctrl;

  localparam int P = 8;
  localparam int B = 2;
  localparam int FRAME = 4 * P;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       lz_en = 1'b0;
  logic [3:0] dig3 = 4'd0, dig2 = 4'd0, dig1 = 4'd0, dig0 = 4'd0;
  logic       sel1, sel2, h, frame_tick;
  logic [3:0] digit;

  display_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .Clk(clk), .Reset_n(rst_n), .En(en), .Lz_en(lz_en),
    .Dig3(dig3), .Dig2(dig2), .Dig1(dig1), .Dig0(dig0),
    .Sel1(sel1), .Sel2(sel2), .H(h), .Digit(digit), .Frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position t within the running frame decides everything.
  bit         active = 1'b0;
  int         t = 0;
  logic [3:0] snap [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  bit         lz_s = 1'b0;
  bit         prev_h = 1'b0;
  logic [1:0] prev_sel = 2'd0;
  int         h_run = 0;
  int         h_cnt [4];

  function automatic bit suppressed(input int k);
    if (!lz_s || k == 3) return 1'b0;
    for (int j = 0; j <= k; j++)
      if (snap[j] != 4'd0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    if (!en) begin
      active = 1'b0;
      t = 0;
    end else begin
      if (active) t = (t + 1) % FRAME;
      else begin
        active = 1'b1;
        t = 0;
      end
      if (t == 0) begin
        snap[0] = dig3; snap[1] = dig2; snap[2] = dig1; snap[3] = dig0;
        lz_s = lz_en;
      end
    end
  endtask

  task automatic model_reset();
    active = 1'b0;
    t = 0;
    snap = '{4'd0, 4'd0, 4'd0, 4'd0};
    lz_s = 1'b0;
    prev_h = 1'b0;
    prev_sel = 2'd0;
    h_run = 0;
  endtask

  // One clock: model advances on the edge, DUT outputs are compared 1ns later,
  // and the task returns at the falling edge so inputs can be driven safely.
  task automatic step();
    int exp_k;
    bit exp_h;
    bit exp_tick;
    @(posedge clk);
    model_edge();
    #1;
    exp_k    = active ? t / P : 0;
    exp_h    = active && ((t % P) < (P - B)) && !suppressed(exp_k);
    exp_tick = active && (t == 0);
    check("h", 32'(h), 32'(exp_h));
    check("sel", 32'({sel1, sel2}), 32'(exp_k));
    check("frame_tick", 32'(frame_tick), 32'(exp_tick));
    if (active) check("digit", 32'(digit), 32'(snap[exp_k]));
    if (h && prev_h) check("sel_hold", 32'({sel1, sel2}), 32'(prev_sel));
    h_run = h ? h_run + 1 : 0;
    if (h) check("h_len", 32'(h_run <= P - B), 32'd1);
    if (h) h_cnt[{sel1, sel2}]++;
    prev_h = h;
    prev_sel = {sel1, sel2};
    @(negedge clk);
  endtask

  task automatic run_to(input int pos);
    for (int n = 0; n < 4 * FRAME && !(active && t == pos); n++) step();
    check("reach_pos", 32'(active && t == pos), 32'd1);
  endtask

  task automatic frame_h_counts(input int e0, input int e1, input int e2, input int e3);
    run_to(FRAME - 1);
    for (int i = 0; i < 4; i++) h_cnt[i] = 0;
    repeat (FRAME) step();
    check("lz_slot0", 32'(h_cnt[0]), 32'(e0));
    check("lz_slot1", 32'(h_cnt[1]), 32'(e1));
    check("lz_slot2", 32'(h_cnt[2]), 32'(e2));
    check("lz_slot3", 32'(h_cnt[3]), 32'(e3));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) h_cnt[i] = 0;
    @(negedge clk);
    check("rst_h", 32'(h), 32'd0);
    check("rst_sel", 32'({sel1, sel2}), 32'd0);
    check("rst_digit", 32'(digit), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);

    // Basic scan with digits 1,2,3,4.
    dig3 = 4'd1; dig2 = 4'd2; dig1 = 4'd3; dig0 = 4'd4;
    en = 1'b1;
    rst_n = 1'b1;
    step();
    check("first_tick", 32'(frame_tick), 32'd1);
    check("first_digit", 32'(digit), 32'd1);
    repeat (2 * FRAME) step();

    // Dig3 change inside slot 2 must wait for the next frame.
    run_to(2 * P + 1);
    dig3 = 4'd9;
    run_to(FRAME - 1);
    check("old_frame_digit", 32'(digit), 32'd4);
    step();
    check("new_frame_tick", 32'(frame_tick), 32'd1);
    check("new_frame_digit", 32'(digit), 32'd9);

    // Leading-zero suppression.
    lz_en = 1'b1;
    dig3 = 4'd0; dig2 = 4'd0; dig1 = 4'd5; dig0 = 4'd0;
    frame_h_counts(0, 0, P - B, P - B);
    dig1 = 4'd0;
    frame_h_counts(0, 0, 0, P - B);

    // Enable drop in the middle of slot 2's show phase.
    lz_en = 1'b0;
    dig3 = 4'd1; dig2 = 4'd2; dig1 = 4'd3; dig0 = 4'd4;
    run_to(FRAME - 1);
    run_to(2 * P + 2);
    en = 1'b0;
    step();
    check("drop_h", 32'(h), 32'd0);
    check("drop_sel", 32'({sel1, sel2}), 32'd0);
    step();
    dig3 = 4'd7;
    en = 1'b1;
    step();
    check("restart_tick", 32'(frame_tick), 32'd1);
    check("restart_digit", 32'(digit), 32'd7);

    // Asynchronous reset in the middle of a lit slot.
    repeat (P + 2) step();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_h", 32'(h), 32'd0);
    check("async_rst_sel", 32'({sel1, sel2}), 32'd0);
    check("async_rst_digit", 32'(digit), 32'd0);
    check("async_rst_tick", 32'(frame_tick), 32'd0);
    model_reset();
    @(negedge clk);
    en = 1'b1;
    rst_n = 1'b1;
    step();
    check("post_rst_tick", 32'(frame_tick), 32'd1);

    // Random traffic; zero digits are frequent to exercise suppression.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(7) == 0) begin
        logic [3:0] v;
        v = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15));
        case ($urandom_range(3))
          0: dig3 = v;
          1: dig2 = v;
          2: dig1 = v;
          default: dig0 = v;
        endcase
      end
      if ($urandom_range(39) == 0) lz_en = ~lz_en;
      en = ($urandom_range(99) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for the four-digit seven-segment display of the parking-lot controller. It sits directly upstream of the 2x4 anode decoder: it drives the decoder's enable `H` and select pair `Sel1`/`Sel2`. In the same cycle it presents the matching 4-bit digit value to the segment encoder. It adds a frame-coherent digit snapshot, an anti-ghosting blank guard between digit slots, and optional leading-zero suppression.

## Interface
- `PRESCALE`, default 50000: Clk cycles per digit slot; legal range 4..2^20.
- `BLANK_CYCLES`, default 1000: cycles at the end of each slot with `H`=0 (ghosting guard); legal range 1..PRESCALE-1.

- `Clk`  in  1  single system clock, rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `En`  in  1  scan enable; 0 blanks the display.
- `Lz_en`  in  1  leading-zero suppression enable.
- `Dig3`  in  4  leftmost (most significant) digit.
- `Dig2`  in  4  digit 2.
- `Dig1`  in  4  digit 1.
- `Dig0`  in  4  rightmost (least significant) digit.
- `Sel1`  out  1  select MSB to decoder.
- `Sel2`  out  1  select LSB to decoder.
- `H`  out  1  decoder enable; 1 = the selected anode is on.
- `Digit`  out  4  snapshot value of the currently selected digit.
- `Frame_tick`  out  1  one-cycle pulse at the start of each frame.

## Operation
- Slot index k = {Sel1,Sel2}. k=0 shows Dig3, k=1 shows Dig2, k=2 shows Dig1, k=3 shows Dig0. This matches the decoder: k=00 drives the leftmost anode.
- FSM states:
  - IDLE: `H`=0, k=0, slot counter cleared. Leave IDLE on the first edge with `En`=1, going to SHOW.
  - SHOW: lasts PRESCALE-BLANK_CYCLES cycles, then goes to GUARD.
  - GUARD: `H`=0 for BLANK_CYCLES cycles. On its last cycle, k increments mod 4 and the FSM goes to SHOW.
- `En`=0 in any state: IDLE on the next edge.
- Snapshot: shadow registers S3..S0 load Dig3..Dig0 on every entry to SHOW with k=0, both from IDLE and on wrap from k=3. `Frame_tick`=1 for exactly that one cycle. Input changes inside a frame never appear until the next frame.
- `Digit` = S[3-k], registered, and updates on the same edge as `Sel1`/`Sel2`.
- Leading-zero suppression, when `Lz_en`=1: slot k is suppressed if S[3-k] and every more-significant shadow digit are 0. A suppressed slot keeps normal timing, `Sel`, and `Digit`, but `H` stays 0 for the whole slot.
  - Slot k=3 is never suppressed.
  - `Lz_en` is sampled with the snapshot.
- Slot counter width is ceil(log2(PRESCALE)). It wraps to 0 at PRESCALE-1. No arithmetic overflow is possible.

## Timing
- Reset values (asynchronous, immediate): `Sel1`=0, `Sel2`=0, `H`=0, `Digit`=0, `Frame_tick`=0. FSM=IDLE, counter=0, S3..S0=0, latched Lz_en=0.
- All outputs are registered. No combinational path from input to output.
- Edge E is the first edge with `En`=1 in IDLE. After E: `H`=1 (unless suppressed), k=0, `Digit`=Dig3 as sampled at E, and `Frame_tick`=1 for one cycle.
- `H`=1 for PRESCALE-BLANK_CYCLES cycles, then 0 for BLANK_CYCLES cycles. k advances on the same edge that `H` re-rises.
- `Sel` never changes while `H`=1.
- Frame period = 4*PRESCALE cycles. `Frame_tick` spacing is exactly 4*PRESCALE.
- `En` falling: the next edge gives `H`=0 and k=0. Re-enabling restarts the frame at k=0 with a fresh snapshot.
- Reset mid-slot returns all outputs to reset values immediately. Operation resumes as from IDLE.

## Test plan
- PRESCALE=8, BLANK_CYCLES=2, `En`=1, Dig3..0=1,2,3,4, `Lz_en`=0 -> per 8-cycle slot, `H` is 6 cycles high then 2 low. k runs 0,1,2,3,0. `Digit` runs 1,2,3,4. `Frame_tick` is high every 32 cycles.
- Change Dig3 from 1 to 9 during slot k=2 -> `Digit` stays 1 in the current frame and becomes 9 only after the next `Frame_tick`.
- `Lz_en`=1, digits 0,0,5,0 -> `H`=0 through slots 0 and 1. `H` pulses in slot 2 (`Digit`=5) and in slot 3 (`Digit`=0). For digits 0,0,0,0, only slot 3 lights.
- Drop `En` mid-SHOW at k=2 -> next edge gives `H`=0 and k=0. Re-raise `En` -> `Frame_tick` fires and `Digit` = the new Dig3.
- Assert `Reset_n`=0 asynchronously mid-slot -> outputs go to 0 without waiting for a clock edge. After release with `En`=1, the first `Frame_tick` occurs on the first edge.
- Check at every cycle that `Sel1`/`Sel2` never change while `H`=1, and that `H` never stays high longer than PRESCALE-BLANK_CYCLES cycles.
